// File: rtl/game_pkg.sv
// Shared definitions for the memory-game code bus.
//   CODE_W      : width of a one-hot button code
//   chk_state_t : pattern checker FSM states
//   is_onehot   : true when exactly one bit of a code is set
package game_pkg;

    localparam int CODE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        PASS = 2'd2,
        FAIL = 2'd3
    } chk_state_t;

    function automatic logic is_onehot(input logic [CODE_W-1:0] code);
        return (code != '0) && ((code & (code - CODE_W'(1))) == '0);
    endfunction

endpackage

// File: rtl/code_ram.sv
// Small register file holding the target code sequence.
//   clk   : write clock
//   we    : write enable
//   waddr : write index
//   wdata : code to store
//   raddr : read index (combinational read)
//   rdata : code at raddr
module code_ram #(
    parameter int DEPTH = 16,
    parameter int W     = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [DEPTH-1:0][W-1:0] mem;

    // Contents need no reset: nothing is read beyond the current length.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pattern_checker.sv
// Stores a target sequence of one-hot button codes and checks a player's
// presses against it in order.
//   clk, rst_n   : clock, synchronous active-low reset
//   clear        : empty the sequence and return to IDLE
//   load_valid/load_code : append a target code (between attempts only)
//   start        : begin an attempt (needs a non-empty sequence)
//   in_valid/in_code     : one player press
//   busy         : attempt in progress
//   match_pulse  : one cycle per correct press
//   pass / fail  : attempt result, held until next start or clear
//   load_err     : one cycle when a load was rejected
//   length       : codes stored
//   progress     : correct presses in the current attempt
module pattern_checker
    import game_pkg::*;
#(
    parameter int  DEPTH = 16,
    localparam int IDX_W = $clog2(DEPTH) + 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              load_valid,
    input  logic [CODE_W-1:0] load_code,
    input  logic              start,
    input  logic              in_valid,
    input  logic [CODE_W-1:0] in_code,
    output logic              busy,
    output logic              match_pulse,
    output logic              pass,
    output logic              fail,
    output logic              load_err,
    output logic [IDX_W-1:0]  length,
    output logic [IDX_W-1:0]  progress
);

    chk_state_t        state_q, state_d;
    logic [IDX_W-1:0]  length_q, length_d;
    logic [IDX_W-1:0]  progress_q, progress_d;
    logic              busy_d, match_d, pass_d, fail_d, lerr_d;
    logic              we;
    logic [CODE_W-1:0] exp_code;
    logic [IDX_W-1:0]  progress_inc;

    // Write index is length itself (no wrap); read index is progress, which
    // stays below length while in PLAY, so the low bits address the RAM.
    code_ram #(.DEPTH(DEPTH), .W(CODE_W)) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (length_q[AW-1:0]),
        .wdata (load_code),
        .raddr (progress_q[AW-1:0]),
        .rdata (exp_code)
    );

    assign progress_inc = progress_q + IDX_W'(1);

    // Commands are taken in priority order clear > start > press > load;
    // a command that is not applicable in the current state falls through.
    always_comb begin
        state_d    = state_q;
        length_d   = length_q;
        progress_d = progress_q;
        pass_d     = pass;
        fail_d     = fail;
        match_d    = 1'b0;
        lerr_d     = 1'b0;
        we         = 1'b0;

        if (clear) begin
            state_d    = IDLE;
            length_d   = '0;
            progress_d = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
        end else if (start && state_q != PLAY && length_q != '0) begin
            state_d    = PLAY;
            progress_d = '0;
            pass_d     = 1'b0;
            fail_d     = 1'b0;
        end else if (in_valid && state_q == PLAY) begin
            // A multi-hot or empty code is always wrong, even if the stored
            // entry were to equal it.
            if (in_code == exp_code && is_onehot(in_code)) begin
                match_d    = 1'b1;
                progress_d = progress_inc;
                if (progress_inc == length_q) begin
                    state_d = PASS;
                    pass_d  = 1'b1;
                end
            end else begin
                state_d = FAIL;
                fail_d  = 1'b1;
            end
        end else if (load_valid) begin
            if (state_q != PLAY && length_q < IDX_W'(DEPTH) && is_onehot(load_code)) begin
                we       = 1'b1;
                length_d = length_q + IDX_W'(1);
            end else begin
                lerr_d = 1'b1;
            end
        end

        busy_d = (state_d == PLAY);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            length_q    <= '0;
            progress_q  <= '0;
            busy        <= 1'b0;
            match_pulse <= 1'b0;
            pass        <= 1'b0;
            fail        <= 1'b0;
            load_err    <= 1'b0;
        end else begin
            state_q     <= state_d;
            length_q    <= length_d;
            progress_q  <= progress_d;
            busy        <= busy_d;
            match_pulse <= match_d;
            pass        <= pass_d;
            fail        <= fail_d;
            load_err    <= lerr_d;
        end
    end

    assign length   = length_q;
    assign progress = progress_q;

endmodule

// File: tb/tb_pattern_checker.sv
module tb_pattern_checker;

    localparam int DEPTH = 16;
    localparam int IDX_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst_n, clear, load_valid, start, in_valid;
    logic [7:0]       load_code, in_code;
    logic             busy, match_pulse, pass, fail, load_err;
    logic [IDX_W-1:0] length, progress;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] seq [DEPTH];

    pattern_checker #(.DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .clear       (clear),
        .load_valid  (load_valid),
        .load_code   (load_code),
        .start       (start),
        .in_valid    (in_valid),
        .in_code     (in_code),
        .busy        (busy),
        .match_pulse (match_pulse),
        .pass        (pass),
        .fail        (fail),
        .load_err    (load_err),
        .length      (length),
        .progress    (progress)
    );

    always #5 clk = ~clk;

    // Advance one edge and sample 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] c);
        load_valid = 1'b1;
        load_code  = c;
        tick();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_press(input logic [7:0] c);
        in_valid = 1'b1;
        in_code  = c;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; load_valid = 1'b0; start = 1'b0; in_valid = 1'b0;
        load_code = '0; in_code = '0;
        for (int i = 0; i < DEPTH; i++) seq[i] = 8'(1 << (i % 8));

        // Reset state
        tick(); tick();
        rst_n = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_match", match_pulse, 0);
        chk("rst_pass", pass, 0);
        chk("rst_fail", fail, 0);
        chk("rst_lerr", load_err, 0);
        chk("rst_len", length, 0);
        chk("rst_prog", progress, 0);

        // Load 01,04,02 and play it correctly
        do_load(8'h01); do_load(8'h04); do_load(8'h02);
        chk("ld3_len", length, 3);
        chk("ld3_lerr", load_err, 0);
        do_start();
        chk("st_busy", busy, 1);
        chk("st_prog", progress, 0);
        do_press(8'h01);
        chk("p1_match", match_pulse, 1);
        chk("p1_prog", progress, 1);
        chk("p1_pass", pass, 0);
        do_press(8'h04);
        chk("p2_match", match_pulse, 1);
        chk("p2_prog", progress, 2);
        do_press(8'h02);
        chk("p3_match", match_pulse, 1);
        chk("p3_prog", progress, 3);
        chk("p3_pass", pass, 1);
        chk("p3_busy", busy, 0);
        tick();
        chk("pass_hold", pass, 1);
        chk("pulse_drop", match_pulse, 0);

        // Grow the sequence while in PASS and replay it
        do_load(8'h10);
        chk("grow_len", length, 4);
        chk("grow_pass", pass, 1);
        chk("grow_lerr", load_err, 0);
        do_start();
        chk("rs_pass", pass, 0);
        chk("rs_busy", busy, 1);
        chk("rs_prog", progress, 0);
        do_press(8'h01); do_press(8'h04); do_press(8'h02);
        chk("rs3_pass", pass, 0);
        do_press(8'h10);
        chk("rs4_match", match_pulse, 1);
        chk("rs4_pass", pass, 1);
        chk("rs4_prog", progress, 4);

        // Wrong second press
        do_start();
        do_press(8'h01);
        chk("w1_match", match_pulse, 1);
        do_press(8'h08);
        chk("w2_match", match_pulse, 0);
        chk("w2_fail", fail, 1);
        chk("w2_pass", pass, 0);
        chk("w2_prog", progress, 1);
        chk("w2_busy", busy, 0);
        do_press(8'h04);
        chk("infail_match", match_pulse, 0);
        chk("infail_prog", progress, 1);
        chk("infail_fail", fail, 1);

        // Multi-hot press that is not a stored code fails
        do_start();
        chk("mh_failclr", fail, 0);
        do_press(8'h05);
        chk("mh_fail", fail, 1);
        chk("mh_prog", progress, 0);

        // Clear mid-PLAY
        do_start();
        do_press(8'h01);
        do_clear();
        chk("clr_busy", busy, 0);
        chk("clr_len", length, 0);
        chk("clr_prog", progress, 0);
        chk("clr_pass", pass, 0);
        chk("clr_fail", fail, 0);

        // Start with empty sequence, press in IDLE
        do_start();
        chk("st0_busy", busy, 0);
        do_press(8'h01);
        chk("idle_match", match_pulse, 0);
        chk("idle_prog", progress, 0);
        chk("idle_fail", fail, 0);

        // Non-one-hot load
        do_load(8'h03);
        chk("nh_lerr", load_err, 1);
        chk("nh_len", length, 0);
        tick();
        chk("nh_lerr_drop", load_err, 0);

        // Fill to DEPTH, overflow, then play all of it
        for (int i = 0; i < DEPTH; i++) do_load(seq[i]);
        chk("full_len", length, DEPTH);
        chk("full_lerr", load_err, 0);
        do_load(8'h01);
        chk("ovf_lerr", load_err, 1);
        chk("ovf_len", length, DEPTH);
        do_start();
        for (int i = 0; i < DEPTH - 1; i++) do_press(seq[i]);
        chk("full15_prog", progress, DEPTH - 1);
        chk("full15_busy", busy, 1);
        do_press(seq[DEPTH-1]);
        chk("full_pass", pass, 1);
        chk("full_prog", progress, DEPTH);

        // Reset mid-PLAY
        do_start();
        do_press(seq[0]);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("mrst_busy", busy, 0);
        chk("mrst_pass", pass, 0);
        chk("mrst_fail", fail, 0);
        chk("mrst_len", length, 0);
        chk("mrst_prog", progress, 0);

        // Load during PLAY rejected
        do_load(8'h01);
        do_start();
        do_load(8'h02);
        chk("pl_lerr", load_err, 1);
        chk("pl_len", length, 1);
        chk("pl_busy", busy, 1);
        do_press(8'h01);
        chk("pl_pass", pass, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
